systolic_tile_ctrl: RTL and testbench

Sequencer for one `systolic_array` tile computation (C = A·B over depth K). It sits between the operand staging buffers and the array. On a `start` handshake it:
- clears the accumulators;
- generates the per-lane skewed valid masks and a feed step index, which the operand buffers use to present row/column elements;
- gates the array clock-enable against operand availability;
- drains the pipeline;
- sequences row-by-row result writeback over a valid/ready channel.

---
 rtl/systolic_tile_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_systolic_tile_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_tile_ctrl
//
// Sequencer for one systolic_array tile computation (C = A*B over depth K).
// After an accepted start it clears the accumulators, steps the operand feed
// with per-lane skewed valid masks, drains the array pipeline and then writes
// the result back row by row over a valid/ready channel.
//
// Optional feature macro: SYSTOLIC_TILE_CTRL_PERF_EN
//   defined   : perf_busy_cyc / perf_stall_cyc are live saturating counters
//   undefined : both perf ports are tied to zero, no counter logic exists
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   start, cfg_k       tile request and reduction depth (sampled on accept)
//   abort              synchronous abort of the running tile
//   busy, done         tile in progress (CLEAR..WB), completion pulse
//   err_zero_k         pulse: start rejected because cfg_k == 0
//   op_ready           operand buffers can supply the current feed step
//   array_en, acc_clr  array clock-enable, accumulator clear
//   feed_step          current feed step index (KW+1 bits)
//   a/b_lane_valid     per-lane skewed operand valid masks
//   wb_valid, wb_ready, wb_row   result writeback channel
//   perf_busy_cyc, perf_stall_cyc  performance counters
// -----------------------------------------------------------------------------
module systolic_tile_ctrl #(
    parameter int unsigned N         = 8,
    parameter int unsigned KW        = 16,
    parameter int unsigned DRAIN_CYC = 2 * N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KW-1:0]        cfg_k,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err_zero_k,
    input  logic                 op_ready,
    output logic                 array_en,
    output logic                 acc_clr,
    output logic [KW:0]          feed_step,
    output logic [N-1:0]         a_lane_valid,
    output logic [N-1:0]         b_lane_valid,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [$clog2(N)-1:0] wb_row,
    output logic [31:0]          perf_busy_cyc,
    output logic [31:0]          perf_stall_cyc
);

    localparam int unsigned RW = $clog2(N);
    localparam int unsigned SW = KW + 1;
    localparam int unsigned CW = KW + 2;
    localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_WB,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] step_q, step_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [RW-1:0] row_q, row_d;
    logic          err_q, err_d;

    logic          accept;
    logic [SW-1:0] last_step;
    logic [N-1:0]  lane_mask;

    assign accept    = (state_q == S_IDLE) && start && !abort && (cfg_k != '0);
    // K >= 1 is guaranteed by the zero-K rejection, so this never underflows.
    assign last_step = SW'(k_q) + SW'(N) - SW'(2);

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        step_d  = step_q;
        drain_d = drain_q;
        row_d   = row_q;
        err_d   = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            step_d  = '0;
            drain_d = '0;
            row_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (cfg_k == '0) begin
                            err_d = 1'b1;
                        end else begin
                            k_d     = cfg_k;
                            state_d = S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    step_d  = '0;
                    state_d = S_FEED;
                end
                S_FEED: begin
                    if (op_ready) begin
                        if (step_q == last_step) begin
                            step_d  = '0;
                            drain_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            step_d = step_q + SW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DW'(DRAIN_CYC - 1)) begin
                        drain_d = '0;
                        row_d   = '0;
                        state_d = S_WB;
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        if (row_q == RW'(N - 1)) begin
                            row_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            step_q  <= '0;
            drain_q <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            step_q  <= step_d;
            drain_q <= drain_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------- lane masks
    // Lane i is valid for steps i .. i+K-1; compared one bit wider so i+K
    // cannot wrap.
    always_comb begin
        lane_mask = '0;
        if (state_q == S_FEED) begin
            for (int unsigned i = 0; i < N; i++) begin
                lane_mask[i] = ({1'b0, step_q} >= CW'(i)) &&
                               ({1'b0, step_q} <  (CW'(i) + CW'(k_q)));
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign busy         = (state_q == S_CLEAR) || (state_q == S_FEED) ||
                          (state_q == S_DRAIN) || (state_q == S_WB);
    assign done         = (state_q == S_DONE);
    assign err_zero_k   = err_q;
    assign acc_clr      = (state_q == S_CLEAR) && !abort;
    assign array_en     = !abort && (((state_q == S_FEED) && op_ready) ||
                                     (state_q == S_DRAIN));
    assign feed_step    = (state_q == S_FEED) ? step_q : '0;
    assign a_lane_valid = lane_mask;
    assign b_lane_valid = lane_mask;
    assign wb_valid     = (state_q == S_WB) && !abort;
    assign wb_row       = row_q;

    // ------------------------------------------------------ perf counters
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Counters are zeroed on accept and again through CLEAR alongside the
    // accumulators; the busy count therefore covers FEED through WB.
    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (accept || (state_q == S_CLEAR)) begin
            perf_busy_d  = '0;
            perf_stall_d = '0;
        end else begin
            if (((state_q == S_FEED) || (state_q == S_DRAIN) || (state_q == S_WB)) &&
                (perf_busy_q != '1)) begin
                perf_busy_d = perf_busy_q + 32'd1;
            end
            if ((state_q == S_FEED) && !op_ready && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy_cyc  = perf_busy_q;
    assign perf_stall_cyc = perf_stall_q;
`else
    assign perf_busy_cyc  = '0;
    assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_tile_ctrl
//
// Self-checking bench for systolic_tile_ctrl (N=8, KW=16, DRAIN_CYC=16).
// Expected writeback rows and the done pulse, each with its cycle offset from
// the start handshake, are queued when a tile is launched and popped when the
// design produces them. Feed steps, lane masks and enables are checked per
// cycle against the tile timeline.
// -----------------------------------------------------------------------------
module tb_systolic_tile_ctrl;

    localparam int N         = 8;
    localparam int KW        = 16;
    localparam int DRAIN_CYC = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [KW-1:0]   cfg_k;
    logic            abort;
    logic            busy;
    logic            done;
    logic            err_zero_k;
    logic            op_ready;
    logic            array_en;
    logic            acc_clr;
    logic [KW:0]     feed_step;
    logic [N-1:0]    a_lane_valid;
    logic [N-1:0]    b_lane_valid;
    logic            wb_valid;
    logic            wb_ready;
    logic [2:0]      wb_row;
    logic [31:0]     perf_busy_cyc;
    logic [31:0]     perf_stall_cyc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int kind;   // 0: writeback row, 1: done pulse
        int row;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    systolic_tile_ctrl #(
        .N         (N),
        .KW        (KW),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_k          (cfg_k),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .err_zero_k     (err_zero_k),
        .op_ready       (op_ready),
        .array_en       (array_en),
        .acc_clr        (acc_clr),
        .feed_step      (feed_step),
        .a_lane_valid   (a_lane_valid),
        .b_lane_valid   (b_lane_valid),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_row         (wb_row),
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [N-1:0] exp_mask(input int s, input int k);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i] = (s >= i) && (s <= i + k - 1);
        end
        return m;
    endfunction

    task automatic check_quiet(input string tag, input bit with_perf);
        check_val({tag, "_busy"},     64'(busy),         64'd0);
        check_val({tag, "_done"},     64'(done),         64'd0);
        check_val({tag, "_array_en"}, 64'(array_en),     64'd0);
        check_val({tag, "_acc_clr"},  64'(acc_clr),      64'd0);
        check_val({tag, "_wb_valid"}, 64'(wb_valid),     64'd0);
        check_val({tag, "_wb_row"},   64'(wb_row),       64'd0);
        check_val({tag, "_step"},     64'(feed_step),    64'd0);
        check_val({tag, "_amask"},    64'(a_lane_valid), 64'd0);
        check_val({tag, "_bmask"},    64'(b_lane_valid), 64'd0);
        if (with_perf) begin
            check_val({tag, "_err"},        64'(err_zero_k),     64'd0);
            check_val({tag, "_perf_busy"},  64'(perf_busy_cyc),  64'd0);
            check_val({tag, "_perf_stall"}, 64'(perf_stall_cyc), 64'd0);
        end
    endtask

    // Launches one tile at the next negedge and follows it to done, abort or
    // reset. Cycle c counts from the start-accept edge (c=1 is CLEAR).
    task automatic run_tile(input int k, input logic [63:0] stall_mask,
                            input int bp_row, input int bp_len,
                            input int abort_at, input int rst_at, input int poke_at);
        int          n_stall = 0;
        int          wb_start;
        int          c = 0;
        int          steps = 0;
        int          rows = 0;
        int          bp_left = bp_len;
        int          seen;
        bit          fin = 1'b0;
        exp_t        e;
        logic [63:0] stalled = '0;

        for (int s = 0; s < k + N - 1; s++) begin
            if (stall_mask[s]) n_stall++;
        end
        wb_start = 2 + (k + N - 1) + n_stall + DRAIN_CYC;
        for (int r = 0; r < N; r++) begin
            e.kind = 0;
            e.row  = r;
            e.cyc  = wb_start + r + ((bp_len > 0 && r >= bp_row) ? bp_len : 0);
            exp_q.push_back(e);
        end
        e.kind = 1;
        e.row  = 0;
        e.cyc  = wb_start + N + bp_len;
        exp_q.push_back(e);

        @(negedge clk);
        start = 1'b1;
        cfg_k = KW'(k);
        #1;
        check_val("pre_start_busy", 64'(busy), 64'd0);

        while (!fin) begin
            @(negedge clk);
            c++;
            start    = (c == poke_at);
            cfg_k    = (c == poke_at) ? KW'(k + 2) : KW'(k);
            abort    = (c == abort_at);
            rst_n    = !(c == rst_at);
            op_ready = 1'b1;
            wb_ready = 1'b1;
            if (c >= 2 && steps < k + N - 1 && stall_mask[steps] && !stalled[steps]) begin
                op_ready       = 1'b0;
                stalled[steps] = 1'b1;
            end
            if (c >= wb_start && rows == bp_row && bp_left > 0) begin
                wb_ready = 1'b0;
                bp_left--;
            end
            #1;

            if (c == abort_at || c == rst_at) begin
                @(negedge clk);
                abort = 1'b0;
                rst_n = 1'b1;
                #1;
                if (c == rst_at) check_quiet("reset_mid", 1'b1);
                else             check_quiet("abort", 1'b0);
                seen = 0;
                repeat (30) begin
                    @(negedge clk);
                    #1;
                    if (done) seen++;
                end
                check_val("abort_no_done", 64'(seen), 64'd0);
                exp_q.delete();
                fin = 1'b1;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_underflow_done", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("done_kind", 64'(e.kind), 64'd1);
                    check_val("done_cycle", 64'(c), 64'(e.cyc));
                end
                check_val("done_busy", 64'(busy), 64'd0);
                check_val("sb_leftover", 64'(exp_q.size()), 64'd0);
                fin = 1'b1;
            end else if (c == 1) begin
                check_val("clr_acc_clr", 64'(acc_clr), 64'd1);
                check_val("clr_array_en", 64'(array_en), 64'd0);
                check_val("clr_busy", 64'(busy), 64'd1);
            end else if (steps < k + N - 1) begin
                check_val("feed_step", 64'(feed_step), 64'(steps));
                check_val("feed_amask", 64'(a_lane_valid), 64'(exp_mask(steps, k)));
                check_val("feed_bmask", 64'(b_lane_valid), 64'(exp_mask(steps, k)));
                check_val("feed_array_en", 64'(array_en), 64'(op_ready));
                if (op_ready) steps++;
            end else if (c < wb_start) begin
                check_val("drain_array_en", 64'(array_en), 64'd1);
                check_val("drain_amask", 64'(a_lane_valid), 64'd0);
                check_val("drain_wb_valid", 64'(wb_valid), 64'd0);
            end else if (rows < N) begin
                check_val("wb_valid", 64'(wb_valid), 64'd1);
                check_val("wb_array_en", 64'(array_en), 64'd0);
                if (!wb_ready) begin
                    check_val("wb_row_hold", 64'(wb_row), 64'(rows));
                end else if (wb_valid) begin
                    if (exp_q.size() == 0) begin
                        check_val("sb_underflow_row", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("row_kind", 64'(e.kind), 64'd0);
                        check_val("wb_row", 64'(wb_row), 64'(e.row));
                        check_val("row_cycle", 64'(c), 64'(e.cyc));
                    end
                    rows++;
                end
            end

            if (!fin && c > 400) begin
                check_val("tile_timeout", 64'(c), 64'(wb_start + N + bp_len));
                exp_q.delete();
                fin = 1'b1;
            end
        end
        start    = 1'b0;
        abort    = 1'b0;
        rst_n    = 1'b1;
        op_ready = 1'b0;
        wb_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        cfg_k    = '0;
        abort    = 1'b0;
        op_ready = 1'b0;
        wb_ready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset", 1'b1);
        rst_n = 1'b1;

        // Plain tile, K=4, no stalls: done at cycle 37.
        run_tile(4, 64'h0, 0, 0, -1, -1, -1);

        // Same tile with one-cycle stalls at steps 2 and 5: done at cycle 39.
        run_tile(4, 64'h24, 0, 0, -1, -1, -1);
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
        check_val("perf_busy", 64'(perf_busy_cyc), 64'd37);
        check_val("perf_stall", 64'(perf_stall_cyc), 64'd2);
`else
        check_val("perf_busy", 64'(perf_busy_cyc), 64'd0);
        check_val("perf_stall", 64'(perf_stall_cyc), 64'd0);
`endif

        // Zero depth is rejected with a single err_zero_k pulse.
        @(negedge clk);
        start = 1'b1;
        cfg_k = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_val("zk_err", 64'(err_zero_k), 64'd1);
        check_val("zk_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        check_val("zk_err_clear", 64'(err_zero_k), 64'd0);
        check_val("zk_busy_after", 64'(busy), 64'd0);

        // Writeback back-pressure: three cycles held at row 4.
        run_tile(4, 64'h0, 4, 3, -1, -1, -1);

        // Abort in the middle of DRAIN, then a K=1 tile completes normally.
        run_tile(4, 64'h0, 0, 0, 2 + 11 + 5, -1, -1);
        run_tile(1, 64'h0, 0, 0, -1, -1, -1);

        // start (with a different depth) during FEED is ignored.
        run_tile(6, 64'h0, 0, 0, -1, -1, 5);

        // Synchronous reset in the middle of writeback.
        run_tile(4, 64'h0, 0, 0, -1, 2 + 11 + 16 + 3, -1);

        // Design is usable again after the reset.
        run_tile(2, 64'h1, 0, 0, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
